// File: rtl/vote_session_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : vote_session_if
// Purpose  : Board-side signal bundle of the five-switch vote session sequencer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface vote_session_if;
  logic [4:0] sw;
  logic       start;
  logic       led;
  logic [2:0] count;
  logic [6:0] seg;
  logic       busy;
  logic       done;

  modport master (
    output sw, start,
    input  led, count, seg, busy, done
  );

  modport slave (
    input  sw, start,
    output led, count, seg, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/vote_session_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : vote_session_ctrl
// Purpose  : Timed ballot capture, serial tally and result display sequencer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module vote_session_ctrl #(
  parameter int unsigned WINDOW_CYCLES = 50_000_000
) (
  input  wire logic     clk,
  input  wire logic     rst,
  vote_session_if.slave vote_io
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_TALLY  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam logic [25:0] TIMER_LAST = 26'(WINDOW_CYCLES - 1);
  localparam logic [2:0]  IDX_LAST   = 3'd4;

  state_t      state_q, state_d;
  logic [4:0]  sw_s1_q, sw_s2_q;
  logic        start_s1_q, start_s2_q, start_s3_q, start_edge_q;
  logic [4:0]  ballot_q, ballot_d;
  logic [25:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  count_q, count_d;
  logic        done_q, done_d;

  // Edge detect is registered so OPEN is entered on the third edge after first sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      start_s3_q   <= 1'b0;
      start_edge_q <= 1'b0;
    end else begin
      sw_s1_q      <= vote_io.sw;
      sw_s2_q      <= sw_s1_q;
      start_s1_q   <= vote_io.start;
      start_s2_q   <= start_s1_q;
      start_s3_q   <= start_s2_q;
      start_edge_q <= start_s2_q & ~start_s3_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ballot_q <= '0;
      timer_q  <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ballot_q <= ballot_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ballot_d = ballot_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    count_d  = count_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESULT: begin
        if (start_edge_q) begin
          state_d  = ST_OPEN;
          ballot_d = '0;
          timer_d  = '0;
          count_d  = '0;
        end
      end
      ST_OPEN: begin
        ballot_d = ballot_q | sw_s2_q;
        timer_d  = timer_q + 26'd1;
        if (timer_q == TIMER_LAST) begin
          state_d = ST_TALLY;
          idx_d   = '0;
        end
      end
      ST_TALLY: begin
        count_d = count_q + {2'b00, ballot_q[idx_q]};
        idx_d   = idx_q + 3'd1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_RESULT;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [6:0] digit;
  always_comb begin
    digit = 7'h7F;
    case (count_q)
      3'd0:    digit = 7'h40;
      3'd1:    digit = 7'h79;
      3'd2:    digit = 7'h24;
      3'd3:    digit = 7'h30;
      3'd4:    digit = 7'h19;
      3'd5:    digit = 7'h12;
      default: digit = 7'h7F;
    endcase
  end

  always_comb begin
    vote_io.seg = 7'h7F;
    case (state_q)
      ST_OPEN, ST_TALLY: vote_io.seg = 7'h3F;
      ST_RESULT:         vote_io.seg = digit;
      default:           vote_io.seg = 7'h7F;
    endcase
  end

  assign vote_io.busy  = (state_q == ST_OPEN) || (state_q == ST_TALLY);
  assign vote_io.led   = (state_q == ST_RESULT) && (count_q >= 3'd3);
  assign vote_io.count = count_q;
  assign vote_io.done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_session_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_vote_session_ctrl
// Purpose  : Directed self-checking bench with a timeline model of a session.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_vote_session_ctrl;

  localparam int W    = 8;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  vote_session_if vif();

  vote_session_ctrl #(.WINDOW_CYCLES(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .vote_io (vif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int digit_of(input int n);
    case (n)
      0: return 'h40;
      1: return 'h79;
      2: return 'h24;
      3: return 'h30;
      4: return 'h19;
      5: return 'h12;
      default: return 'h7F;
    endcase
  endfunction

  // Session model: pin history per clock edge; a session started at edge S is OPEN
  // after edges S..S+W-1, TALLY after S+W..S+W+4, RESULT from S+W+5 on.
  logic [4:0] sw_hist [0:HMAX-1];
  logic       st_hist [0:HMAX-1];
  int         ecnt = 0;
  int         sess_s = -1;

  function automatic logic [4:0] model_ballot(input int s);
    logic [4:0] b;
    b = '0;
    for (int e = s - 1; e <= s + W - 2; e++)
      if (e >= 0 && e < HMAX) b = b | sw_hist[e];
    return b;
  endfunction

  initial begin
    for (int i = 0; i < HMAX; i++) begin
      sw_hist[i] = '0;
      st_hist[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    int d, t, e_led, e_cnt, e_seg, e_busy, e_done;
    logic [4:0] b;
    logic was_busy;
    ecnt = ecnt + 1;
    if (ecnt < HMAX) begin
      if (rst) begin
        sw_hist[ecnt] = '0;
        st_hist[ecnt] = 1'b0;
        sess_s = -1;
      end else begin
        sw_hist[ecnt] = vif.sw;
        st_hist[ecnt] = vif.start;
        was_busy = (sess_s >= 0) && (ecnt - 1 >= sess_s) && (ecnt - 1 < sess_s + W + 5);
        if (ecnt >= 4 && st_hist[ecnt-3] && !st_hist[ecnt-4] && !was_busy)
          sess_s = ecnt;
      end
    end
    #1;
    if (!rst) begin
      e_led = 0; e_cnt = 0; e_seg = 'h7F; e_busy = 0; e_done = 0;
      if (sess_s >= 0) begin
        d = ecnt - sess_s;
        b = model_ballot(sess_s);
        if (d < W) begin
          e_seg = 'h3F; e_busy = 1;
        end else if (d < W + 5) begin
          t = d - W;
          e_cnt  = $countones(b & 5'((1 << t) - 1));
          e_seg  = 'h3F;
          e_busy = 1;
        end else begin
          e_cnt  = $countones(b);
          e_led  = (e_cnt >= 3) ? 1 : 0;
          e_seg  = digit_of(e_cnt);
          e_done = (d == W + 5) ? 1 : 0;
        end
      end
      check("cyc_led",   int'(vif.led),   e_led);
      check("cyc_count", int'(vif.count), e_cnt);
      check("cyc_seg",   int'(vif.seg),   e_seg);
      check("cyc_busy",  int'(vif.busy),  e_busy);
      check("cyc_done",  int'(vif.done),  e_done);
    end
  end

  // Called at a negedge; returns at the negedge of the first RESULT cycle.
  task automatic run_session(input logic [4:0] sw_val, input int sw_from, input int sw_to,
                             input int p1, input int p2, output int busy_n);
    int lat;
    bit got;
    vif.start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      vif.start = 1'b0;
    end while (!vif.busy && lat < 20);
    check("start_latency", lat, 4);
    check("open_count", int'(vif.count), 0);
    check("open_led",   int'(vif.led),   0);
    check("open_seg",   int'(vif.seg),   'h3F);
    busy_n = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      vif.start = (i == p1 || i == p2);
      if (i == sw_from) vif.sw = sw_val;
      if (i == sw_to)   vif.sw = '0;
      if (vif.busy) busy_n++;
      if (vif.done) got = 1'b1;
      else @(negedge clk);
    end
    vif.start = 1'b0;
    check("session_done", int'(got), 1);
  endtask

  initial begin
    int bn;
    vif.sw = '0;
    vif.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a window.
    vif.sw = 5'b11111;
    vif.start = 1'b1;
    repeat (4) @(negedge clk);
    vif.start = 1'b0;
    check("pre_reset_busy", int'(vif.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_led",   int'(vif.led),   0);
    check("rst_count", int'(vif.count), 0);
    check("rst_seg",   int'(vif.seg),   'h7F);
    check("rst_busy",  int'(vif.busy),  0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    vif.sw = '0;
    repeat (10) @(negedge clk);
    check("idle_busy", int'(vif.busy), 0);
    check("idle_seg",  int'(vif.seg),  'h7F);

    // Basic majority 10101.
    vif.sw = 5'b10101;
    run_session(5'b10101, -1, -1, -1, -1, bn);
    check("basic_busy_cycles", bn, 13);
    check("basic_count", int'(vif.count), 3);
    check("basic_led",   int'(vif.led),   1);
    check("basic_seg",   int'(vif.seg),   'h30);
    @(negedge clk);
    check("basic_done_once", int'(vif.done), 0);
    vif.sw = '0;
    repeat (3) @(negedge clk);

    // Sticky ballots: short pulses still count.
    run_session(5'b11001, 0, 3, -1, -1, bn);
    check("sticky_a_count", int'(vif.count), 3);
    check("sticky_a_led",   int'(vif.led),   1);
    repeat (3) @(negedge clk);
    run_session(5'b00110, 0, 3, -1, -1, bn);
    check("sticky_b_count", int'(vif.count), 2);
    check("sticky_b_led",   int'(vif.led),   0);
    check("sticky_b_seg",   int'(vif.seg),   'h24);
    repeat (3) @(negedge clk);

    // Window edge: last sample that can still reach the capture.
    run_session(5'b00100, 5, -1, -1, -1, bn);
    check("edge_in_count", int'(vif.count), 1);
    vif.sw = '0;
    repeat (3) @(negedge clk);
    run_session(5'b00100, 6, -1, -1, -1, bn);
    check("edge_out_count", int'(vif.count), 0);
    vif.sw = '0;
    repeat (3) @(negedge clk);

    // Start pulses during OPEN and during the last TALLY cycle are ignored.
    vif.sw = 5'b11111;
    run_session(5'b11111, -1, -1, 2, 9, bn);
    check("ignore_busy_cycles", bn, 13);
    check("all_count", int'(vif.count), 5);
    check("all_led",   int'(vif.led),   1);
    check("all_seg",   int'(vif.seg),   'h12);
    vif.sw = '0;
    repeat (3) @(negedge clk);

    // Restart from RESULT(5) with no votes.
    run_session(5'b00000, -1, -1, -1, -1, bn);
    check("zero_count", int'(vif.count), 0);
    check("zero_led",   int'(vif.led),   0);
    check("zero_seg",   int'(vif.seg),   'h40);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
